// File: rtl/ifetch_icache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_icache_pkg
// Brief    : Shared widths, constants and fetch FSM encoding for ifetch_icache.
// Revision : 1.0
// ============================================================================
package ifetch_icache_pkg;

    localparam int AddrLen = 32;
    localparam int InstLen = 32;

    localparam logic [InstLen-1:0] ZERO_WORD = '0;

    localparam logic True  = 1'b1;
    localparam logic False = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MISS = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/ifetch_icache_set_array.sv
`default_nettype none
// ============================================================================
// Module   : icache_set_array
// Brief    : Per-way tag/valid/data storage with parallel lookup, victim
//            selection and per-set round-robin replacement pointer.
// Revision : 1.0
// ============================================================================
module icache_set_array
    import ifetch_icache_pkg::*;
#(
    parameter int INST_W    = 32,
    parameter int SETS_LOG2 = 7,
    parameter int WAYS      = 2,
    parameter int TAG_W     = 23
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic [SETS_LOG2-1:0] rd_idx_i,
    input  logic [TAG_W-1:0]     rd_tag_i,
    output logic                 hit_o,
    output logic [INST_W-1:0]    hit_data_o,
    input  logic                 fill_i,
    input  logic [SETS_LOG2-1:0] fill_idx_i,
    input  logic [TAG_W-1:0]     fill_tag_i,
    input  logic [INST_W-1:0]    fill_data_i,
    input  logic                 inv_all_i
);

    localparam int SETS  = 1 << SETS_LOG2;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAY_W-1:0]  ptr_q   [SETS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [INST_W-1:0] data_q  [SETS][WAYS];

    logic [WAY_W-1:0]  w_victim;

    // At most one way can match, so OR-ing the matching data is a clean mux.
    always_comb begin
        hit_o      = False;
        hit_data_o = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[rd_idx_i][w] && (tag_q[rd_idx_i][w] == rd_tag_i)) begin
                hit_o      = True;
                hit_data_o = hit_data_o | data_q[rd_idx_i][w];
            end
        end
    end

    // Descending scan leaves the lowest-indexed invalid way as the victim.
    always_comb begin
        w_victim = ptr_q[fill_idx_i];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[fill_idx_i][w]) begin
                w_victim = WAY_W'(w);
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
        end else if (rdy) begin
            if (inv_all_i) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_q[s] <= '0;
                end
            end else if (fill_i) begin
                valid_q[fill_idx_i][w_victim] <= True;
            end
            if (fill_i) begin
                ptr_q[fill_idx_i] <= (WAYS == 1) ? '0 : ptr_q[fill_idx_i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rdy && fill_i) begin
            tag_q[fill_idx_i][w_victim]  <= fill_tag_i;
            data_q[fill_idx_i][w_victim] <= fill_data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ifetch_icache.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_icache
// Brief    : Instruction-fetch stage with N-way set-associative I-cache and
//            request/done miss handshake to the memory controller.
// Revision : 1.0
// ============================================================================
module ifetch_icache
    import ifetch_icache_pkg::*;
#(
    parameter int ADDR_W    = AddrLen,
    parameter int INST_W    = InstLen,
    parameter int SETS_LOG2 = 7,
    parameter int WAYS      = 2
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              rdy,
    input  logic              pc_valid_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              flush_i,
    input  logic              inv_all_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [INST_W-1:0] inst_o,
    output logic              inst_valid_o,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [INST_W-1:0] mem_inst_i,
    input  logic              mem_done_i
);

    localparam int TAG_W = ADDR_W - SETS_LOG2 - 2;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] miss_pc_q, miss_pc_d;
    logic              mem_req_q, mem_req_d;
    logic              inst_valid_q, inst_valid_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;

    logic              w_hit;
    logic [INST_W-1:0] w_hit_data;
    logic              w_fill;

    icache_set_array #(
        .INST_W    (INST_W),
        .SETS_LOG2 (SETS_LOG2),
        .WAYS      (WAYS),
        .TAG_W     (TAG_W)
    ) u_set_array (
        .clk_in      (clk_in),
        .rst         (rst),
        .rdy         (rdy),
        .rd_idx_i    (pc_i[SETS_LOG2+1:2]),
        .rd_tag_i    (pc_i[ADDR_W-1:SETS_LOG2+2]),
        .hit_o       (w_hit),
        .hit_data_o  (w_hit_data),
        .fill_i      (w_fill),
        .fill_idx_i  (miss_pc_q[SETS_LOG2+1:2]),
        .fill_tag_i  (miss_pc_q[ADDR_W-1:SETS_LOG2+2]),
        .fill_data_i (mem_inst_i),
        .inv_all_i   (inv_all_i)
    );

    always_comb begin
        state_d      = state_q;
        miss_pc_d    = miss_pc_q;
        mem_req_d    = mem_req_q;
        inst_valid_d = False;
        pc_d         = pc_q;
        inst_d       = inst_q;
        w_fill       = False;
        case (state_q)
            IDLE: begin
                if (pc_valid_i && !flush_i && !inv_all_i) begin
                    if (w_hit) begin
                        inst_valid_d = True;
                        pc_d         = pc_i;
                        inst_d       = w_hit_data;
                    end else begin
                        miss_pc_d = pc_i;
                        mem_req_d = True;
                        state_d   = MISS;
                    end
                end
            end
            MISS: begin
                if (mem_done_i) begin
                    w_fill    = True;
                    mem_req_d = False;
                    state_d   = IDLE;
                    if (!flush_i) begin
                        inst_valid_d = True;
                        pc_d         = miss_pc_q;
                        inst_d       = mem_inst_i;
                    end
                end else if (flush_i) begin
                    state_d = DROP;
                end
            end
            // The controller cannot abort, so a cancelled miss still fills.
            DROP: begin
                if (mem_done_i) begin
                    w_fill    = True;
                    mem_req_d = False;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = False;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            miss_pc_q    <= '0;
            mem_req_q    <= False;
            inst_valid_q <= False;
            pc_q         <= '0;
            inst_q       <= ZERO_WORD[INST_W-1:0];
        end else if (rdy) begin
            state_q      <= state_d;
            miss_pc_q    <= miss_pc_d;
            mem_req_q    <= mem_req_d;
            inst_valid_q <= inst_valid_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
        end
    end

    assign stall_o      = (state_q != IDLE);
    assign mem_req_o    = mem_req_q;
    assign mem_addr_o   = {miss_pc_q[ADDR_W-1:2], 2'b00};
    assign inst_valid_o = inst_valid_q;
    assign pc_o         = pc_q;
    assign inst_o       = inst_q;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_icache.sv
`default_nettype none
// Scoreboard bench for ifetch_icache: the driver predicts hit/miss from an
// abstract cache model and queues expected deliveries; a monitor checks them.
module tb_ifetch_icache;

    localparam int SETS_LOG2 = 7;
    localparam int SETS      = 1 << SETS_LOG2;
    localparam int WAYS      = 2;

    logic        clk_in = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        pc_valid_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic        flush_i = 1'b0;
    logic        inv_all_i = 1'b0;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        stall_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_inst_i = '0;
    logic        mem_done_i = 1'b0;

    ifetch_icache #(
        .ADDR_W    (32),
        .INST_W    (32),
        .SETS_LOG2 (SETS_LOG2),
        .WAYS      (WAYS)
    ) dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .rdy          (rdy),
        .pc_valid_i   (pc_valid_i),
        .pc_i         (pc_i),
        .flush_i      (flush_i),
        .inv_all_i    (inv_all_i),
        .pc_o         (pc_o),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o),
        .stall_o      (stall_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_inst_i   (mem_inst_i),
        .mem_done_i   (mem_done_i)
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    // Reference cache: sets of WAYS lines, lowest free way else round-robin.
    bit          m_valid [SETS][WAYS];
    logic [22:0] m_tag   [SETS][WAYS];
    int          m_ptr   [SETS];

    function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endfunction

    function automatic logic [31:0] mem_word(logic [31:0] a);
        if (a == 32'h0000_1000) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
        end
    endfunction

    function automatic bit model_hit(logic [31:0] pc);
        int s = int'(pc[8:2]);
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_tag[s][w] == pc[31:9]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_fill(logic [31:0] pc, bit inv);
        int s = int'(pc[8:2]);
        int v = m_ptr[s];
        for (int w = WAYS - 1; w >= 0; w--)
            if (!m_valid[s][w]) v = w;
        if (inv) model_reset_valid();
        m_tag[s][v] = pc[31:9];
        if (!inv) m_valid[s][v] = 1'b1;
        m_ptr[s] = (m_ptr[s] + 1) % WAYS;
    endfunction

    function automatic void model_reset_valid();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
    endfunction

    // Monitor: every active edge either matches the head of the queue or must be silent.
    always @(posedge clk_in) begin
        bit   act;
        exp_t e;
        cyc++;
        act = rdy && !rst;
        #1;
        if (act && !rst) begin
            if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                chk("deliver_valid", {31'd0, inst_valid_o}, 32'd1);
                if (inst_valid_o) begin
                    chk("deliver_pc", pc_o, e.pc);
                    chk("deliver_inst", inst_o, e.inst);
                end
            end else if (inst_valid_o) begin
                total++;
                bad++;
                $display("FAIL unexpected_delivery: got pc %h inst %h, required no delivery", pc_o, inst_o);
            end
        end
    end

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_pc", pc_o, 32'd0);
        chk("rst_inst", inst_o, 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        model_reset();
        @(negedge clk_in);
        rst = 1'b0;
    endtask

    // Entered and left at a negedge. flush_cyc<0 means no flush.
    task automatic do_fetch(input logic [31:0] pc, input int lat, input int flush_cyc,
                            input bit inv_on_done, input int rdy_hold);
        bit          hit = model_hit(pc);
        bit          dropped = 1'b0;
        logic [31:0] aligned = {pc[31:2], 2'b00};
        pc_valid_i = 1'b1;
        pc_i       = pc;
        if (hit) exp_q.push_back('{pc, mem_word(aligned), cyc + 1});
        @(negedge clk_in);
        pc_valid_i = 1'b0;
        if (hit) begin
            chk("hit_no_req", {31'd0, mem_req_o}, 32'd0);
            chk("hit_no_stall", {31'd0, stall_o}, 32'd0);
            return;
        end
        chk("miss_req", {31'd0, mem_req_o}, 32'd1);
        chk("miss_stall", {31'd0, stall_o}, 32'd1);
        chk("miss_addr", mem_addr_o, aligned);
        for (int c = 1; c <= lat; c++) begin
            if (c == flush_cyc) begin
                flush_i = 1'b1;
                dropped = 1'b1;
            end
            if (c == lat) begin
                mem_done_i = 1'b1;
                mem_inst_i = mem_word(aligned);
                inv_all_i  = inv_on_done;
                if (!dropped) exp_q.push_back('{pc, mem_word(aligned), cyc + 1 + rdy_hold});
                if (rdy_hold > 0) begin
                    rdy = 1'b0;
                    repeat (rdy_hold) begin
                        @(negedge clk_in);
                        chk("frozen_req", {31'd0, mem_req_o}, 32'd1);
                        chk("frozen_stall", {31'd0, stall_o}, 32'd1);
                    end
                    rdy = 1'b1;
                end
            end
            @(negedge clk_in);
            flush_i    = 1'b0;
            mem_done_i = 1'b0;
            inv_all_i  = 1'b0;
            if (c < lat) begin
                chk("req_held", {31'd0, mem_req_o}, 32'd1);
                chk("addr_held", mem_addr_o, aligned);
            end
        end
        model_fill(aligned, inv_on_done);
        chk("req_dropped", {31'd0, mem_req_o}, 32'd0);
        chk("idle_after_fill", {31'd0, stall_o}, 32'd0);
    endtask

    task automatic flush_with_pc(input logic [31:0] pc);
        pc_valid_i = 1'b1;
        pc_i       = pc;
        flush_i    = 1'b1;
        @(negedge clk_in);
        pc_valid_i = 1'b0;
        flush_i    = 1'b0;
        chk("flushpc_no_req", {31'd0, mem_req_o}, 32'd0);
        chk("flushpc_no_stall", {31'd0, stall_o}, 32'd0);
    endtask

    task automatic do_inv();
        inv_all_i = 1'b1;
        @(negedge clk_in);
        inv_all_i = 1'b0;
        model_reset_valid();
    endtask

    initial begin
        #1;
        apply_reset();
        @(negedge clk_in);

        // Cold miss with 3-cycle memory, then a 1-cycle hit.
        do_fetch(32'h0000_1000, 3, -1, 1'b0, 0);
        do_fetch(32'h0000_1000, 3, -1, 1'b0, 0);

        // Three lines into set 0 of a 2-way cache: third evicts way 0.
        do_fetch(32'h0000_3000, 2, -1, 1'b0, 0);
        do_fetch(32'h0000_5000, 2, -1, 1'b0, 0);
        do_fetch(32'h0000_3000, 2, -1, 1'b0, 0);
        do_fetch(32'h0000_1000, 2, -1, 1'b0, 0);

        // Flush one cycle after the request, then refetch hits the dropped fill.
        do_fetch(32'h0000_2004, 3, 1, 1'b0, 0);
        do_fetch(32'h0000_2004, 3, -1, 1'b0, 0);
        // Flush on the done edge.
        do_fetch(32'h0000_2408, 2, 2, 1'b0, 0);
        do_fetch(32'h0000_2408, 2, -1, 1'b0, 0);

        flush_with_pc(32'h0000_2004);
        flush_with_pc(32'h0000_7777);

        do_inv();
        do_fetch(32'h0000_1000, 2, -1, 1'b0, 0);
        do_fetch(32'h0000_4010, 2, -1, 1'b1, 0);
        do_fetch(32'h0000_4010, 2, -1, 1'b0, 0);

        // Memory stalled by rdy=0 for 4 cycles with done held.
        do_fetch(32'h0000_6020, 2, -1, 1'b0, 4);
        do_fetch(32'h0000_6020, 2, -1, 1'b0, 0);

        // Asynchronous reset in the middle of a miss.
        do_fetch(32'h0000_3000, 1, -1, 1'b0, 0);
        pc_valid_i = 1'b1;
        pc_i       = 32'h0000_8000;
        @(negedge clk_in);
        pc_valid_i = 1'b0;
        chk("pre_rst_req", {31'd0, mem_req_o}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_req", {31'd0, mem_req_o}, 32'd0);
        chk("async_rst_stall", {31'd0, stall_o}, 32'd0);
        model_reset();
        @(negedge clk_in);
        rst = 1'b0;
        @(negedge clk_in);
        do_fetch(32'h0000_3000, 2, -1, 1'b0, 0);

        // Randomised traffic over a few sets and tags to force conflicts.
        for (int i = 0; i < 300; i++) begin
            int          r   = $urandom_range(0, 19);
            int          lat = $urandom_range(1, 4);
            logic [31:0] pc  = ($urandom_range(0, 4) << 9) | ($urandom_range(0, 3) << 2)
                             | $urandom_range(0, 3);
            if (r == 0) do_inv();
            else if (r == 1) flush_with_pc(pc);
            else do_fetch(pc, lat, (r < 5) ? $urandom_range(1, lat) : -1, (r == 5),
                          (r == 6) ? $urandom_range(1, 3) : 0);
        end

        repeat (3) @(negedge clk_in);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
